// File: rtl/mdu_sequencer_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: op encodings, FSM states, widths.
// No logic here; latency and backpressure are defined by mdu_sequencer.
package mdu_sequencer_pkg;

  localparam int         MDU_XLEN    = 32;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIXUP,
    ST_DONE
  } mdu_state_e;

endpackage

// File: rtl/mdu_sequencer_if.sv
// Core <-> MDU bundle: issue side (start/flush/operands) and result side (stall/busy/wb_*).
// Pure wiring; stall is the only backpressure and is driven by the MDU.
interface mdu_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_addr;
  logic            stall;
  logic            busy;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;

  modport master (
    output start, flush, funct3, rs1_val, rs2_val, rd_addr,
    input  stall, busy, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  start, flush, funct3, rs1_val, rs2_val, rd_addr,
    output stall, busy, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/mdu_sequencer_step.sv
// One iteration of shift-add multiply or restoring divide on a {hi,lo} accumulator.
// Purely combinational, zero latency, no backpressure.
module mdu_sequencer_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_operand,
  input  logic              i_div,
  output logic [2*XLEN-1:0] o_acc,
  output logic              o_qbit
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rsh;
  logic [XLEN-1:0] w_diff;

  always_comb begin
    w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    w_rsh  = i_acc[2*XLEN-1:XLEN-1];
    o_qbit = (w_rsh >= {1'b0, i_operand});
    // when the subtract succeeds the result is below the divisor, so XLEN bits suffice
    w_diff = w_rsh[XLEN-1:0] - i_operand;
    if (i_div) begin
      o_acc = {(o_qbit ? w_diff : w_rsh[XLEN-1:0]), i_acc[XLEN-2:0], 1'b0};
    end else begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multi-cycle mul/div controller; stalls the core from issue until the writeback cycle.
// Latency: writeback at cycle XLEN+3 (cycle 2 for div-by-zero/overflow); flush aborts with no writeback.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter  int XLEN  = MDU_XLEN,
  localparam int CNT_W = $clog2(XLEN)
) (
  input logic           clk,
  input logic           rst,
  mdu_sequencer_if.slave bus
);

  mdu_state_e        r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  mdu_op_e           r_op, w_in_op;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_a, r_b;
  logic              r_qneg, r_rneg;
  logic [2*XLEN-1:0] r_acc;
  logic [4:0]        r_wb_addr;
  logic [XLEN-1:0]   r_wb_data;

  logic              w_sa, w_sb, w_issue;
  logic              w_is_div, w_is_rem, w_div_zero, w_ovf;
  logic [XLEN-1:0]   w_a_orig, w_quo, w_rem, w_spec_res, w_fix_res, w_res;
  logic [2*XLEN-1:0] w_prod, w_step_acc;
  logic              w_qbit, w_stall, w_wb_en, w_load;

  mdu_sequencer_step #(.XLEN(XLEN)) u_step (
    .i_acc     (r_acc),
    .i_operand (r_b),
    .i_div     (w_is_div),
    .o_acc     (w_step_acc),
    .o_qbit    (w_qbit)
  );

  always_comb begin
    w_in_op = mdu_op_e'(bus.funct3);
    w_issue = bus.start & ~bus.flush;
    w_sa    = bus.rs1_val[XLEN-1] & (w_in_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    w_sb    = bus.rs2_val[XLEN-1] & (w_in_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  end

  // Operands are held as magnitudes; r_qneg is the product/quotient sign, r_rneg the dividend sign.
  always_comb begin
    w_is_div   = r_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    w_is_rem   = r_op inside {OP_REM, OP_REMU};
    w_a_orig   = r_rneg ? -r_a : r_a;
    w_prod     = r_qneg ? -r_acc : r_acc;
    w_quo      = r_qneg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem      = r_rneg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    w_div_zero = w_is_div && (r_b == '0);
    w_ovf      = (r_op inside {OP_DIV, OP_REM}) && r_rneg && !r_qneg &&
                 (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (r_b == XLEN'(1));
    if (w_is_rem) begin
      w_spec_res = w_div_zero ? w_a_orig : '0;
    end else begin
      w_spec_res = w_div_zero ? '1 : w_a_orig;
    end
    unique case (r_op)
      OP_MUL:                       w_fix_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fix_res = w_quo;
      default:                      w_fix_res = w_rem;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_wb_en = 1'b0;
    w_load  = 1'b0;
    w_res   = '0;
    unique case (r_state)
      ST_IDLE: begin
        w_stall = w_issue;
        if (w_issue) w_next = ST_PREP;
      end
      ST_PREP: begin
        w_stall = 1'b1;
        if (w_div_zero || w_ovf) begin
          w_next = ST_DONE;
          w_load = 1'b1;
          w_res  = w_spec_res;
        end else begin
          w_next = ST_CALC;
        end
      end
      ST_CALC: begin
        w_stall = 1'b1;
        if (r_cnt == '0) w_next = ST_FIXUP;
      end
      ST_FIXUP: begin
        w_stall = 1'b1;
        w_next  = ST_DONE;
        w_load  = 1'b1;
        w_res   = w_fix_res;
      end
      ST_DONE: begin
        w_wb_en = (r_rd != '0);
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (bus.flush) begin
      w_next  = ST_IDLE;
      w_stall = 1'b0;
      w_wb_en = 1'b0;
      w_load  = 1'b0;
    end
    // outputs must read zero for the whole time reset is asserted, even with start high
    if (!rst) w_stall = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= OP_MUL;
      r_rd      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_acc     <= '0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_issue) begin
        r_op   <= w_in_op;
        r_rd   <= bus.rd_addr;
        r_a    <= w_sa ? -bus.rs1_val : bus.rs1_val;
        r_b    <= w_sb ? -bus.rs2_val : bus.rs2_val;
        r_qneg <= w_sa ^ w_sb;
        r_rneg <= w_sa;
      end
      if (r_state == ST_PREP) begin
        r_cnt <= CNT_W'(XLEN-1);
        r_acc <= {{XLEN{1'b0}}, r_a};
      end
      if (r_state == ST_CALC) begin
        r_cnt <= r_cnt - CNT_W'(1);
        r_acc <= w_is_div ? {w_step_acc[2*XLEN-1:1], w_qbit} : w_step_acc;
      end
      if (w_load) begin
        r_wb_data <= w_res;
        r_wb_addr <= r_rd;
      end
    end
  end

  assign bus.stall   = w_stall;
  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.wb_en   = w_wb_en;
  assign bus.wb_addr = r_wb_addr;
  assign bus.wb_data = r_wb_data;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: results, writeback timing, stall window, flush and reset.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   wb_total = 0;

  always #5 clk = ~clk;

  mdu_sequencer_if #(.XLEN(32)) bus();

  mdu_sequencer dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always @(negedge clk) begin
    #2;
    if (bus.wb_en === 1'b1) wb_total++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat,
                        output int wb_cyc, output int wb_n, output logic [31:0] d,
                        output logic [4:0] ad, output int stall_err);
    wb_cyc = -1; wb_n = 0; d = '0; ad = '0; stall_err = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b0; bus.funct3 = op;
    bus.rs1_val = a; bus.rs2_val = b; bus.rd_addr = rd;
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus.stall !== (c < lat)) stall_err++;
      if (bus.wb_en === 1'b1) begin
        wb_n++;
        if (wb_cyc < 0) begin
          wb_cyc = c; d = bus.wb_data; ad = bus.wb_addr;
        end
      end
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.rs1_val = '0; bus.rs2_val = '0; bus.rd_addr = '0;
    #12;
    n_chk++;
    if ({bus.stall, bus.busy, bus.wb_en} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: stall/busy/wb_en=%b expected 000", {bus.stall, bus.busy, bus.wb_en});
    end
    n_chk++;
    if (bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_wb: addr=%0d data=%h expected 0/0", bus.wb_addr, bus.wb_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int cyc, n, se; logic [31:0] d; logic [4:0] ad;
    run_op(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 35, cyc, n, d, ad, se);
    n_chk++;
    if (d !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_data: got %h expected ffffffeb", d); end
    n_chk++;
    if (ad !== 5'd5) begin n_fail++; $display("FAIL mul_addr: got %0d expected 5", ad); end
    n_chk++;
    if (cyc !== 35 || n !== 1) begin n_fail++; $display("FAIL mul_timing: wb at %0d count %0d expected 35/1", cyc, n); end
    n_chk++;
    if (se !== 0) begin n_fail++; $display("FAIL mul_stall: %0d bad stall cycles expected 0", se); end
    go_idle();
  endtask

  task automatic test_mul_high();
    mdu_op_e     ops[3] = '{OP_MULHU, OP_MULH, OP_MULHSU};
    logic [31:0] va[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vb[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
    logic [31:0] ve[3]  = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF};
    int cyc, n, se; logic [31:0] d; logic [4:0] ad;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], va[i], vb[i], 5'd7, 35, cyc, n, d, ad, se);
      n_chk++;
      if (d !== ve[i]) begin n_fail++; $display("FAIL mulh_data[%0d]: got %h expected %h", i, d, ve[i]); end
      n_chk++;
      if (cyc !== 35 || n !== 1 || se !== 0) begin
        n_fail++; $display("FAIL mulh_timing[%0d]: wb at %0d count %0d stallerr %0d expected 35/1/0", i, cyc, n, se);
      end
    end
    go_idle();
  endtask

  task automatic test_div_special();
    mdu_op_e     ops[6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] va[6]  = '{32'h80000000, 32'h80000000, 32'h64, 32'h64, 32'h5, 32'hFFFFFFFB};
    logic [31:0] vb[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] ve[6]  = '{32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'h64, 32'hFFFFFFFF, 32'hFFFFFFFB};
    int cyc, n, se; logic [31:0] d; logic [4:0] ad;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], va[i], vb[i], 5'd9, 2, cyc, n, d, ad, se);
      n_chk++;
      if (d !== ve[i]) begin n_fail++; $display("FAIL special_data[%0d]: got %h expected %h", i, d, ve[i]); end
      n_chk++;
      if (cyc !== 2 || n !== 1 || se !== 0) begin
        n_fail++; $display("FAIL special_timing[%0d]: wb at %0d count %0d stallerr %0d expected 2/1/0", i, cyc, n, se);
      end
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    mdu_op_e     ops[6] = '{OP_DIV, OP_REM, OP_DIVU, OP_DIVU, OP_REMU, OP_MUL};
    logic [31:0] va[6]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h64, 32'hFFFFFFF9, 32'h10000};
    logic [31:0] vb[6]  = '{32'h2, 32'h2, 32'h2, 32'h0, 32'h2, 32'h10001};
    logic [31:0] ve[6]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'hFFFFFFFF, 32'h1, 32'h00010000};
    int          vl[6]  = '{35, 35, 35, 2, 35, 35};
    int cyc, n, se, w0; logic [31:0] d; logic [4:0] ad;
    w0 = wb_total;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], va[i], vb[i], 5'(i + 1), vl[i], cyc, n, d, ad, se);
      n_chk++;
      if (d !== ve[i] || ad !== 5'(i + 1)) begin
        n_fail++; $display("FAIL b2b_result[%0d]: got %h rd %0d expected %h rd %0d", i, d, ad, ve[i], i + 1);
      end
      n_chk++;
      if (cyc !== vl[i] || n !== 1 || se !== 0) begin
        n_fail++; $display("FAIL b2b_timing[%0d]: wb at %0d count %0d stallerr %0d expected %0d/1/0", i, cyc, n, se, vl[i]);
      end
    end
    go_idle();
    #3;
    n_chk++;
    if (wb_total - w0 !== 6) begin n_fail++; $display("FAIL b2b_count: %0d writebacks expected 6", wb_total - w0); end
  endtask

  task automatic test_rd_zero();
    int cyc, n, se, w0; logic [31:0] d; logic [4:0] ad;
    w0 = wb_total;
    run_op(OP_MUL, 32'd3, 32'd4, 5'd0, 35, cyc, n, d, ad, se);
    n_chk++;
    if (n !== 0) begin n_fail++; $display("FAIL rd0_wb: %0d wb_en pulses expected 0", n); end
    n_chk++;
    if (se !== 0) begin n_fail++; $display("FAIL rd0_stall: %0d bad stall cycles expected 0", se); end
    go_idle();
    #3;
    n_chk++;
    if (wb_total !== w0) begin n_fail++; $display("FAIL rd0_count: %0d writebacks expected 0", wb_total - w0); end
  endtask

  task automatic test_flush();
    int w0;
    w0 = wb_total;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = OP_MUL; bus.rs1_val = 32'd3; bus.rs2_val = 32'd5; bus.rd_addr = 5'd8;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    n_chk++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", bus.stall); end
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    #1;
    n_chk++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
    repeat (40) @(negedge clk);
    #3;
    n_chk++;
    if (wb_total !== w0) begin n_fail++; $display("FAIL flush_nowb: %0d writebacks expected 0", wb_total - w0); end
    // abort in the writeback cycle itself
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 35; c++) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    n_chk++;
    if (bus.wb_en !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL flush_done: wb_en=%b busy=%b expected 0/1", bus.wb_en, bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1;
    #1;
    n_chk++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_start_stall: got %b expected 0", bus.stall); end
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    n_chk++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_midop();
    int w0;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = OP_MUL; bus.rs1_val = 32'd6; bus.rs2_val = 32'd7; bus.rd_addr = 5'd12;
    for (int c = 1; c <= 20; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.stall, bus.busy, bus.wb_en} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_ctrl: stall/busy/wb_en=%b expected 000", {bus.stall, bus.busy, bus.wb_en});
    end
    n_chk++;
    if (bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0) begin
      n_fail++; $display("FAIL midrst_wb: addr=%0d data=%h expected 0/0", bus.wb_addr, bus.wb_data);
    end
    w0 = wb_total;
    @(negedge clk);
    rst_n = 1'b1; bus.start = 1'b0;
    repeat (40) @(negedge clk);
    #3;
    n_chk++;
    if (wb_total !== w0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_drop: %0d writebacks busy=%b expected 0/0", wb_total - w0, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div_special();
    test_back_to_back();
    test_rd_zero();
    test_flush();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
